// File: rtl/data_mem_responder_if.sv
// Load/store bus between the pipeline memory stage and the data memory responder.
// The master drives the request; the slave returns load data and the misalignment flag.
interface data_mem_responder_if;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadData;
    logic        misaligned;

    modport master (
        output MemWriteM, funct3M, ALUResultM, WriteDataM,
        input  ReadData, misaligned
    );

    modport slave (
        input  MemWriteM, funct3M, ALUResultM, WriteDataM,
        output ReadData, misaligned
    );
endinterface

// File: rtl/data_mem_responder.sv
// RV32I data memory: byte-lane RAM with combinational reads, plus an MMIO page
// holding an LED register, a free-running cycle counter and a committed-store counter.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output logic                 err_sticky,
    output logic [7:0]           leds
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [23:0] MMIO_PAGE = MMIO_BASE[31:8];

    logic [AW-1:0] ram_idx;
    logic          in_ram;
    logic          in_mmio;
    logic          sel_led;
    logic          sel_cyc;
    logic          sel_st;
    logic          st_misal;
    logic          st_bad_size;
    logic          st_ok;
    logic [3:0]    be;
    logic [3:0]    ram_be;
    logic [31:0]   wdata;
    logic [31:0]   ram_word;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   rd_data;

    logic [7:0]    leds_q, leds_d;
    logic [31:0]   cyc_q, cyc_d;
    logic [31:0]   st_cnt_q, st_cnt_d;
    logic          err_q, err_d;

    assign ram_idx = bus.ALUResultM[AW+1:2];
    assign in_ram  = (bus.ALUResultM[31:AW+2] == '0);

    // Address decode and store qualification
    always_comb begin
        in_mmio = (bus.ALUResultM[31:8] == MMIO_PAGE);
        sel_led = in_mmio && (bus.ALUResultM[7:2] == 6'd0);
        sel_cyc = in_mmio && (bus.ALUResultM[7:2] == 6'd1);
        sel_st  = in_mmio && (bus.ALUResultM[7:2] == 6'd2);

        st_misal = bus.MemWriteM &&
                   (((bus.funct3M == 3'b001) && bus.ALUResultM[0]) ||
                    ((bus.funct3M == 3'b010) && (bus.ALUResultM[1:0] != 2'b00)));
        st_bad_size = bus.MemWriteM && (bus.funct3M[2] || (bus.funct3M[1:0] == 2'b11));
        st_ok = bus.MemWriteM && !st_misal && !st_bad_size;

        wdata = bus.WriteDataM;
        be    = 4'b0000;
        case (bus.funct3M)
            3'b000: begin
                wdata = {4{bus.WriteDataM[7:0]}};
                be    = 4'b0001 << bus.ALUResultM[1:0];
            end
            3'b001: begin
                wdata = {2{bus.WriteDataM[15:0]}};
                be    = bus.ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (!st_ok) be = 4'b0000;
        ram_be = in_ram ? be : 4'b0000;
    end

    // Each byte lane is its own array so partial stores never need read-modify-write.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                end else if (ram_be[gi]) begin
                    lane_mem[ram_idx] <= wdata[gi*8 +: 8];
                end
            end

            assign ram_word[gi*8 +: 8] = lane_mem[ram_idx];
        end
    endgenerate

    // Load path: pick the source word, then extract and extend the lane
    always_comb begin
        rd_word = '0;
        if (in_ram)       rd_word = ram_word;
        else if (sel_led) rd_word = {24'h0, leds_q};
        else if (sel_cyc) rd_word = cyc_q;
        else if (sel_st)  rd_word = st_cnt_q;

        rd_byte = rd_word[{bus.ALUResultM[1:0], 3'b000} +: 8];
        rd_half = bus.ALUResultM[1] ? rd_word[31:16] : rd_word[15:0];

        case (bus.funct3M)
            3'b000:  rd_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  rd_data = rd_word;
            3'b100:  rd_data = {24'h0, rd_byte};
            3'b101:  rd_data = {16'h0, rd_half};
            default: rd_data = '0;
        endcase
    end

    // Only lane 0 of the LED word is backed by storage, so other-lane stores fall away.
    always_comb begin
        leds_d   = (sel_led && be[0]) ? wdata[7:0] : leds_q;
        cyc_d    = cyc_q + 32'd1;
        st_cnt_d = st_cnt_q;
        if (in_ram && st_ok) st_cnt_d = st_cnt_q + 32'd1;
        err_d    = err_q || st_misal || st_bad_size;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds_q   <= 8'h00;
            cyc_q    <= 32'h0;
            st_cnt_q <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            leds_q   <= leds_d;
            cyc_q    <= cyc_d;
            st_cnt_q <= st_cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.ReadData   = rd_data;
    assign bus.misaligned = st_misal;
    assign err_sticky     = err_q;
    assign leds           = leds_q;
endmodule
